sobel_ctrl: RTL
===============

Name: sobel_ctrl

Overview:
Job controller for the Sobel AFU. Decodes HardCloud MMIO CSR writes (DSM base, control, input/output buffer descriptors) and holds the core datapath in reset until released. On START it launches the read (fetch) and write engines, waits for both to finish, then posts a 64-bit completion record to the DSM. Sits between the CCI-P MMIO decode path and the Sobel read/write engines.

Parameters:
HC_BUFFER_SIZE, 2, number of buffer descriptors; buffer 0 = input image, buffer 1 = output image
CYC_W, 32, width of the run-cycle counter

Ports:
clk  in  1  AFU clock
reset  in  1  synchronous active-high reset
mmio_wr_valid  in  1  MMIO write strobe, one cycle per write
mmio_addr  in  16  MMIO dword address (byte address >> 2)
mmio_wr_data  in  64  MMIO write data
core_reset  out  1  reset to read/write engines and Sobel pipeline
rd_start  out  1  one-cycle launch pulse to read engine
rd_base  out  64  buffer 0 address
rd_size  out  32  buffer 0 size in bytes
rd_done  in  1  one-cycle pulse: read engine finished
wr_start  out  1  one-cycle launch pulse to write engine
wr_base  out  64  buffer 1 address
wr_size  out  32  buffer 1 size in bytes
wr_done  in  1  one-cycle pulse: write engine finished, last line committed
dsm_wr_valid  out  1  completion record valid
dsm_wr_addr  out  64  completion record address (= DSM base)
dsm_wr_data  out  64  {cycles[31:0], status[31:0]}
dsm_wr_ready  in  1  completion record accepted
busy  out  1  high in S_RUN and S_DSM

Behaviour:
- CSR map (byte address; decode on mmio_addr = byte>>2): 0x110 DSM base (64b); 0x118 control (data[31:0]); 0x120+0x10*i buffer i address (64b); 0x128+0x10*i buffer i size (data[31:0]), i < HC_BUFFER_SIZE. Other addresses ignored.
- CSR writes take effect the cycle after mmio_wr_valid. DSM base and descriptor writes ignored in S_RUN and S_DSM (locked).
- Reset: all CSRs 0, state S_RST, core_reset=1, all other outputs 0, cycle counter 0.
- States: S_RST, S_READY, S_RUN, S_DSM.
- Control values: 0x0 ASSERT_RST, 0x1 DEASSERT_RST, 0x3 START, 0x7 STOP; any other value ignored.
- S_RST: core_reset=1. DEASSERT_RST -> S_READY (core_reset=0 next cycle).
- ASSERT_RST from any state -> S_RST; pending dsm_wr_valid dropped, done flags cleared.
- S_READY: START with rd_size!=0 and wr_size!=0 -> rd_start=wr_start=1 for exactly one cycle (first cycle of S_RUN), counter cleared to 0, done flags cleared, -> S_RUN. START with either size 0 -> status=3 (bad descriptor), -> S_DSM without launching. STOP ignored.
- S_RUN: counter +1 per cycle, saturates at 2^CYC_W-1. rd_done/wr_done set sticky flags; both in the same cycle allowed. When both flags set (including the cycle the second arrives) -> status=1, -> S_DSM. STOP -> status=2, -> S_DSM; STOP in the same cycle as completion: completion wins, status=1. START ignored.
- S_DSM: dsm_wr_valid=1, addr/data stable until dsm_wr_ready; on handshake -> S_READY, dsm_wr_valid=0 next cycle. done pulses in S_DSM/S_READY ignored.
- rd_base/rd_size/wr_base/wr_size reflect CSRs continuously; stable during a run (locked).

Test Plan:
- Reset, write ctrl 0x1, descriptors buf0=0x1000/4096, buf1=0x8000/4096, DSM=0x200, START; rd_done at +10, wr_done at +20 -> rd_start/wr_start one pulse, dsm_wr_data={20-ish exact cycle count,1}, dsm_wr_addr=0x200, back to S_READY.
- rd_done and wr_done same cycle at run cycle 5 -> single DSM record, status 1, cycles=5.
- START with buf1 size 0 -> no start pulses, DSM record status 3, cycles 0.
- STOP at run cycle 7 before any done -> status 2; STOP coinciding with final done -> status 1.
- Write buf0 address 0xDEAD during S_RUN -> rd_base unchanged; same write in S_READY -> rd_base=0xDEAD.
- Hold dsm_wr_ready=0 for 5 cycles then ASSERT_RST -> dsm_wr_valid drops, core_reset=1, no record accepted; ctrl 0x5 ignored in any state.

Source files
------------

// File: rtl/sobel_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_ctrl : job controller for the Sobel AFU.
//
// Decodes MMIO CSR writes (DSM base, control, buffer descriptors), holds the
// Sobel core in reset until released, launches the read/write engines on
// START, waits for both to report completion and then posts a 64-bit
// completion record {cycles[31:0], status[31:0]} to the DSM base address.
//
// Ports
//   clk, reset            : AFU clock, synchronous active-high reset
//   mmio_wr_valid         : one-cycle MMIO write strobe
//   mmio_addr             : MMIO dword address (byte address >> 2)
//   mmio_wr_data          : MMIO write data
//   core_reset            : reset to read/write engines and Sobel pipeline
//   rd_start/rd_base/rd_size, rd_done : read engine launch, buffer 0, finish
//   wr_start/wr_base/wr_size, wr_done : write engine launch, buffer 1, finish
//   dsm_wr_valid/addr/data, dsm_wr_ready : completion record handshake
//   busy                  : high while a job is running or its record pends
// -----------------------------------------------------------------------------
module sobel_ctrl #(
  parameter int HC_BUFFER_SIZE = 2,
  parameter int CYC_W          = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mmio_wr_valid,
  input  logic [15:0] mmio_addr,
  input  logic [63:0] mmio_wr_data,
  output logic        core_reset,
  output logic        rd_start,
  output logic [63:0] rd_base,
  output logic [31:0] rd_size,
  input  logic        rd_done,
  output logic        wr_start,
  output logic [63:0] wr_base,
  output logic [31:0] wr_size,
  input  logic        wr_done,
  output logic        dsm_wr_valid,
  output logic [63:0] dsm_wr_addr,
  output logic [63:0] dsm_wr_data,
  input  logic        dsm_wr_ready,
  output logic        busy
);

  // CSR dword addresses (byte address >> 2)
  localparam logic [15:0] ADDR_DSM_BASE = 16'h0044;  // byte 0x110
  localparam logic [15:0] ADDR_CTRL     = 16'h0046;  // byte 0x118
  localparam logic [15:0] ADDR_BUF_ADDR = 16'h0048;  // byte 0x120 + 0x10*i
  localparam logic [15:0] ADDR_BUF_SIZE = 16'h004A;  // byte 0x128 + 0x10*i

  // Control command encodings
  localparam logic [31:0] CMD_ASSERT_RST   = 32'h0000_0000;
  localparam logic [31:0] CMD_DEASSERT_RST = 32'h0000_0001;
  localparam logic [31:0] CMD_START        = 32'h0000_0003;
  localparam logic [31:0] CMD_STOP         = 32'h0000_0007;

  // Completion status codes
  localparam logic [31:0] STATUS_DONE = 32'd1;
  localparam logic [31:0] STATUS_STOP = 32'd2;
  localparam logic [31:0] STATUS_BAD  = 32'd3;

  localparam logic [CYC_W-1:0] CNT_ONE = CYC_W'(1);
  localparam logic [CYC_W-1:0] CNT_MAX = {CYC_W{1'b1}};

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_READY = 2'd1,
    S_RUN   = 2'd2,
    S_DSM   = 2'd3
  } state_t;

  state_t              r_state;
  logic [63:0]         r_dsm_base;
  logic [63:0]         r_buf_addr [HC_BUFFER_SIZE];
  logic [31:0]         r_buf_size [HC_BUFFER_SIZE];
  logic                r_core_reset;
  logic                r_rd_start;
  logic                r_wr_start;
  logic                r_dsm_valid;
  logic [63:0]         r_dsm_data;
  logic                r_busy;
  logic                r_rd_done;
  logic                r_wr_done;
  logic [CYC_W-1:0]    r_cnt;

  logic                      w_locked;
  logic                      w_dsm_wr;
  logic [HC_BUFFER_SIZE-1:0] w_buf_addr_wr;
  logic [HC_BUFFER_SIZE-1:0] w_buf_size_wr;
  logic                      w_cmd_assert;
  logic                      w_cmd_deassert;
  logic                      w_cmd_start;
  logic                      w_cmd_stop;
  logic                      w_rd_seen;
  logic                      w_wr_seen;
  logic                      w_both_done;
  logic                      w_sizes_ok;
  logic [31:0]               w_cyc32;

  // MMIO decode: write enables for each CSR and control command strobes
  always_comb begin
    w_locked       = (r_state == S_RUN) || (r_state == S_DSM);
    w_dsm_wr       = 1'b0;
    w_buf_addr_wr  = '0;
    w_buf_size_wr  = '0;
    w_cmd_assert   = 1'b0;
    w_cmd_deassert = 1'b0;
    w_cmd_start    = 1'b0;
    w_cmd_stop     = 1'b0;
    if (mmio_wr_valid) begin
      w_dsm_wr = (mmio_addr == ADDR_DSM_BASE) && !w_locked;
      for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
        w_buf_addr_wr[i] = (mmio_addr == (ADDR_BUF_ADDR + 16'(4 * i))) && !w_locked;
        w_buf_size_wr[i] = (mmio_addr == (ADDR_BUF_SIZE + 16'(4 * i))) && !w_locked;
      end
      if (mmio_addr == ADDR_CTRL) begin
        w_cmd_assert   = (mmio_wr_data[31:0] == CMD_ASSERT_RST);
        w_cmd_deassert = (mmio_wr_data[31:0] == CMD_DEASSERT_RST);
        w_cmd_start    = (mmio_wr_data[31:0] == CMD_START);
        w_cmd_stop     = (mmio_wr_data[31:0] == CMD_STOP);
      end else begin
        w_cmd_assert   = 1'b0;
      end
    end else begin
      w_dsm_wr = 1'b0;
    end
  end

  // Completion detection: a done pulse counts in the cycle it arrives
  always_comb begin
    w_rd_seen   = r_rd_done | rd_done;
    w_wr_seen   = r_wr_done | wr_done;
    w_both_done = w_rd_seen & w_wr_seen;
    w_sizes_ok  = (r_buf_size[0] != 32'd0) && (r_buf_size[1] != 32'd0);
    w_cyc32     = 32'(r_cnt);
  end

  // CSR storage; descriptors and DSM base are frozen while a job is active
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dsm_base <= 64'd0;
      for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
        r_buf_addr[i] <= 64'd0;
        r_buf_size[i] <= 32'd0;
      end
    end else begin
      if (w_dsm_wr) begin
        r_dsm_base <= mmio_wr_data;
      end
      for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
        if (w_buf_addr_wr[i]) begin
          r_buf_addr[i] <= mmio_wr_data;
        end
        if (w_buf_size_wr[i]) begin
          r_buf_size[i] <= mmio_wr_data[31:0];
        end
      end
    end
  end

  // Job FSM with registered launch pulses, cycle counter and DSM record
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_RST;
      r_core_reset <= 1'b1;
      r_rd_start   <= 1'b0;
      r_wr_start   <= 1'b0;
      r_dsm_valid  <= 1'b0;
      r_dsm_data   <= 64'd0;
      r_busy       <= 1'b0;
      r_rd_done    <= 1'b0;
      r_wr_done    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      // Launch pulses last exactly one cycle
      r_rd_start <= 1'b0;
      r_wr_start <= 1'b0;
      if (w_cmd_assert) begin
        // ASSERT_RST overrides everything, including a pending record
        r_state      <= S_RST;
        r_core_reset <= 1'b1;
        r_dsm_valid  <= 1'b0;
        r_busy       <= 1'b0;
        r_rd_done    <= 1'b0;
        r_wr_done    <= 1'b0;
      end else begin
        case (r_state)
          S_RST: begin
            if (w_cmd_deassert) begin
              r_state      <= S_READY;
              r_core_reset <= 1'b0;
            end
          end
          S_READY: begin
            if (w_cmd_start) begin
              r_cnt     <= '0;
              r_rd_done <= 1'b0;
              r_wr_done <= 1'b0;
              r_busy    <= 1'b1;
              if (w_sizes_ok) begin
                r_rd_start <= 1'b1;
                r_wr_start <= 1'b1;
                r_state    <= S_RUN;
              end else begin
                // Empty buffer: report a bad descriptor without launching
                r_dsm_data  <= {32'd0, STATUS_BAD};
                r_dsm_valid <= 1'b1;
                r_state     <= S_DSM;
              end
            end
          end
          S_RUN: begin
            if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + CNT_ONE;
            end
            r_rd_done <= w_rd_seen;
            r_wr_done <= w_wr_seen;
            // Completion takes priority over a simultaneous STOP
            if (w_both_done) begin
              r_dsm_data  <= {w_cyc32, STATUS_DONE};
              r_dsm_valid <= 1'b1;
              r_state     <= S_DSM;
            end else if (w_cmd_stop) begin
              r_dsm_data  <= {w_cyc32, STATUS_STOP};
              r_dsm_valid <= 1'b1;
              r_state     <= S_DSM;
            end
          end
          S_DSM: begin
            if (r_dsm_valid && dsm_wr_ready) begin
              r_dsm_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_state     <= S_READY;
            end
          end
          default: begin
            r_state      <= S_RST;
            r_core_reset <= 1'b1;
            r_dsm_valid  <= 1'b0;
            r_busy       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign core_reset   = r_core_reset;
  assign rd_start     = r_rd_start;
  assign wr_start     = r_wr_start;
  assign rd_base      = r_buf_addr[0];
  assign rd_size      = r_buf_size[0];
  assign wr_base      = r_buf_addr[1];
  assign wr_size      = r_buf_size[1];
  assign dsm_wr_valid = r_dsm_valid;
  assign dsm_wr_addr  = r_dsm_base;
  assign dsm_wr_data  = r_dsm_data;
  assign busy         = r_busy;

endmodule
